bambu_offchip_mem_model: RTL and testbench
==========================================

Name: bambu_offchip_mem_model

Overview:
Synthesizable, parametrised off-chip RAM model for Bambu-generated accelerators. It serves N_CH independent master channels (Mout_* bus) with configurable read and write latency, byte-masked writes, and a DataRdy handshake. A byte-wide preload port fills the array from the bench before start. It replaces the ad-hoc per-testbench memory logic and can also be used on FPGA as a latency-accurate scratch RAM.

Parameters:
N_CH, 2, number of master channels
ADDR_W, 7, address bits per channel (byte address)
DATA_W, 8, data bits per channel; multiple of 8, range 8..64
BASE_ADDR, 0, first byte address owned by this model
MEM_BYTES, 32, bytes owned; window is [BASE_ADDR, BASE_ADDR+MEM_BYTES)
READ_DELAY, 2, read latency in cycles; must be >=2
WRITE_DELAY, 1, write latency in cycles; must be >=1
SIZE_W, 7, width of each per-channel size field (bits)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low
Mout_oe_ram  in  N_CH  per-channel read request
Mout_we_ram  in  N_CH  per-channel write request
Mout_addr_ram  in  N_CH*ADDR_W  per-channel byte address, channel c at [c*ADDR_W +: ADDR_W]
Mout_Wdata_ram  in  N_CH*DATA_W  per-channel write data
Mout_data_ram_size  in  N_CH*SIZE_W  access size in bits
M_Rdata_ram  out  N_CH*DATA_W  read data; 0 when not returning data
M_DataRdy  out  N_CH  one-cycle completion pulse per channel
load_en  in  1  preload strobe
load_addr  in  ADDR_W  preload byte address
load_data  in  8  preload byte
err_conflict  out  N_CH  sticky: oe and we both high on the channel
err_range  out  N_CH  sticky: in-window access whose bytes run past the window end

Behaviour:
- Reset (reset=0, async): all latency counters 0, M_DataRdy=0, M_Rdata_ram=0, err_* =0. Array contents are not reset.
- Hit: request on channel c is "in window" when its address is in [BASE_ADDR, BASE_ADDR+MEM_BYTES). Out-of-window requests are ignored: no DataRdy, no write, Rdata=0.
- Master holds oe/we, addr, data, and size stable until DataRdy; the model never back-pressures otherwise.
- Per-channel counter cnt[c]: increments each cycle the in-window request is held. Resets to 0 in the DataRdy cycle, when the request drops, or when the request type changes.
- Read: first request cycle t. Rdata register is loaded at the edge ending cycle t+READ_DELAY-2 with bytes addr..addr+DATA_W/8-1 (pre-edge contents). DataRdy=1 and Rdata valid in cycle t+READ_DELAY-1. Bits at or above size are zero.
- Write: array updated at the edge ending cycle t+WRITE_DELAY-1. DataRdy=1 in that cycle (combinational from cnt==WRITE_DELAY-1). Only bits below size are written; within a partial byte, bits outside the mask keep their old value.
- Size: size=0 or size>DATA_W is treated as DATA_W.
- Range error: bytes beyond BASE_ADDR+MEM_BYTES-1 are not written and read as 0; err_range[c] is set.
- Back-to-back: if the master keeps oe high after DataRdy, the next cycle starts a new access with cnt=0.
- Same-byte write collision in one edge: the highest channel index wins.
- Cross-channel read/write in the same edge: the read sees the old data.
- Conflict: oe&we both high on an in-window channel sets err_conflict[c]. That channel then performs no access and returns no DataRdy until the conflict clears.
- Preload: when load_en=1 and load_addr is in the window, the byte is written at the edge. A channel write to the same byte in the same edge overrides the preload. Preload never raises DataRdy.
- Reset mid-access: the access is aborted and no DataRdy is issued. A write with cnt<WRITE_DELAY-1 has not modified the array.

Test Plan:
- Preload 0x11,0x22 at addr 0,1; ch0 oe, addr 1, size 8, READ_DELAY=2 -> DataRdy[0] exactly 1 cycle after request start, Rdata[7:0]=0x22.
- DATA_W=16, ch1 write 0xABCD addr 4 size 8, then read addr 4 size 16 -> Rdata=0x00CD (upper byte preserved from prior 0, lower 0xCD).
- Both channels write addr 3 (ch0 0x55, ch1 0xAA) same cycle -> subsequent read returns 0xAA.
- ch0 oe addr 100 with BASE_ADDR=0, MEM_BYTES=32 -> no DataRdy for 10 cycles, Rdata=0, err_range=0.
- ch0 oe=we=1 addr 2 -> err_conflict[0]=1 next cycle, no DataRdy, array unchanged; stays 1 until reset.
- READ_DELAY=4; assert reset during cycle 2 of a read -> outputs 0 immediately, no DataRdy after release; a fresh read then completes in 4 cycles.

Source files
------------

// File: rtl/bambu_offchip_mem_model.sv
// -----------------------------------------------------------------------------
// bambu_offchip_mem_model
//   Latency-accurate off-chip RAM model shared by N_CH independent masters.
//   Each channel issues a read (oe) or write (we) and holds it, together with
//   address, data and size, until M_DataRdy pulses. Reads return data
//   READ_DELAY-1 cycles after the first request cycle; writes commit
//   WRITE_DELAY-1 cycles after it. A byte-wide preload port fills the array.
//
// Handshake: a channel request is held stable by the master. M_DataRdy[c]
//   is high for exactly one cycle, which ends that access. If the request is
//   still high in the following cycle, that cycle starts a new access.
//
// Ports
//   clock, reset               rising-edge clock, asynchronous active-low reset
//   Mout_oe_ram / Mout_we_ram  per-channel read / write request
//   Mout_addr_ram              per-channel byte address (ADDR_W each)
//   Mout_Wdata_ram             per-channel write data (DATA_W each)
//   Mout_data_ram_size         per-channel access size in bits (SIZE_W each)
//   M_Rdata_ram                per-channel read data, zero unless returning
//   M_DataRdy                  per-channel one-cycle completion pulse
//   load_en/addr/data          byte preload port
//   err_conflict               sticky: oe and we together on an in-window channel
//   err_range                  sticky: in-window access running past window end
// -----------------------------------------------------------------------------
module bambu_offchip_mem_model #(
    parameter int N_CH        = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int BASE_ADDR   = 0,
    parameter int MEM_BYTES   = 32,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1,
    parameter int SIZE_W      = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_CH-1:0]        Mout_oe_ram,
    input  logic [N_CH-1:0]        Mout_we_ram,
    input  logic [N_CH*ADDR_W-1:0] Mout_addr_ram,
    input  logic [N_CH*DATA_W-1:0] Mout_Wdata_ram,
    input  logic [N_CH*SIZE_W-1:0] Mout_data_ram_size,
    output logic [N_CH*DATA_W-1:0] M_Rdata_ram,
    output logic [N_CH-1:0]        M_DataRdy,
    input  logic                   load_en,
    input  logic [ADDR_W-1:0]      load_addr,
    input  logic [7:0]             load_data,
    output logic [N_CH-1:0]        err_conflict,
    output logic [N_CH-1:0]        err_range
);
    localparam int NB   = DATA_W / 8;
    localparam int MAXD = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int MW   = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    localparam logic [CW-1:0] RD_LOAD = CW'(READ_DELAY - 2);
    localparam logic [CW-1:0] RD_DONE = CW'(READ_DELAY - 1);
    localparam logic [CW-1:0] WR_DONE = CW'(WRITE_DELAY - 1);

    function automatic logic in_window(input int a);
        return (a >= BASE_ADDR) && (a < BASE_ADDR + MEM_BYTES);
    endfunction

    // Size 0 or anything wider than the bus means a full-width access.
    function automatic int eff_size(input logic [SIZE_W-1:0] s);
        int v;
        v = int'(s);
        if (v == 0 || v > DATA_W) v = DATA_W;
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] size_mask(input int sz);
        logic [DATA_W:0] m;
        m = ((DATA_W+1)'(1) << sz) - (DATA_W+1)'(1);
        return m[DATA_W-1:0];
    endfunction

    logic [CW-1:0]     cnt_q   [N_CH];
    logic [CW-1:0]     cnt_d   [N_CH];
    logic [CW-1:0]     cnt_eff [N_CH];
    logic [DATA_W-1:0] rdata_q [N_CH];
    logic [DATA_W-1:0] rdata_d [N_CH];
    logic [DATA_W-1:0] rd_word [N_CH];
    logic [DATA_W-1:0] mask    [N_CH];
    int                off     [N_CH];
    int                sz      [N_CH];
    logic [N_CH-1:0]   typ_q, typ_d;  // 1 = last cycle was a write request
    logic [N_CH-1:0]   err_conflict_q, err_conflict_d;
    logic [N_CH-1:0]   err_range_q, err_range_d;
    logic [N_CH-1:0]   hit, valid, rd_load, rd_done, wr_done;

    logic [7:0]        mem_q  [MEM_BYTES];
    logic              wr_en  [N_CH][NB];
    logic [MW-1:0]     wr_idx [N_CH][NB];
    logic [7:0]        wr_val [N_CH][NB];
    logic              ld_hit;
    logic [MW-1:0]     ld_idx;

    always_comb begin
        hit            = '0;
        valid          = '0;
        rd_load        = '0;
        rd_done        = '0;
        wr_done        = '0;
        typ_d          = Mout_we_ram;
        err_conflict_d = err_conflict_q;
        err_range_d    = err_range_q;
        for (int c = 0; c < N_CH; c++) begin
            hit[c]  = in_window(int'(Mout_addr_ram[c*ADDR_W +: ADDR_W]));
            off[c]  = hit[c] ? int'(Mout_addr_ram[c*ADDR_W +: ADDR_W]) - BASE_ADDR : 0;
            sz[c]   = eff_size(Mout_data_ram_size[c*SIZE_W +: SIZE_W]);
            mask[c] = size_mask(sz[c]);
            // A conflicting channel (oe and we together) performs no access.
            valid[c] = reset && hit[c] && (Mout_oe_ram[c] != Mout_we_ram[c]);
            // A change of request type restarts the count from zero.
            cnt_eff[c] = (typ_q[c] == Mout_we_ram[c]) ? cnt_q[c] : '0;

            rd_load[c] = valid[c] && !Mout_we_ram[c] && (cnt_eff[c] == RD_LOAD);
            rd_done[c] = valid[c] && !Mout_we_ram[c] && (cnt_eff[c] == RD_DONE);
            wr_done[c] = valid[c] &&  Mout_we_ram[c] && (cnt_eff[c] == WR_DONE);
            cnt_d[c]   = (valid[c] && !(rd_done[c] || wr_done[c])) ? cnt_eff[c] + CW'(1) : '0;

            // Bytes past the window end read as zero and are never written.
            for (int b = 0; b < NB; b++) begin
                rd_word[c][b*8 +: 8] = (hit[c] && (off[c] + b < MEM_BYTES)) ?
                                       mem_q[MW'(off[c] + b)] : 8'h00;
                wr_en[c][b]  = wr_done[c] && (off[c] + b < MEM_BYTES) &&
                               (mask[c][b*8 +: 8] != 8'h00);
                wr_idx[c][b] = MW'(off[c] + b);
                wr_val[c][b] = (mem_q[MW'(off[c] + b)] & ~mask[c][b*8 +: 8]) |
                               (Mout_Wdata_ram[c*DATA_W + b*8 +: 8] & mask[c][b*8 +: 8]);
            end
            rdata_d[c] = rd_load[c] ? (rd_word[c] & mask[c]) : rdata_q[c];

            if (hit[c] && Mout_oe_ram[c] && Mout_we_ram[c])
                err_conflict_d[c] = 1'b1;
            if (valid[c] && (off[c] + (sz[c] + 7) / 8 > MEM_BYTES))
                err_range_d[c] = 1'b1;
        end
        ld_hit = load_en && in_window(int'(load_addr));
        ld_idx = MW'(int'(load_addr) - BASE_ADDR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c]   <= '0;
                rdata_q[c] <= '0;
            end
            typ_q          <= '0;
            err_conflict_q <= '0;
            err_range_q    <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c]   <= cnt_d[c];
                rdata_q[c] <= rdata_d[c];
            end
            typ_q          <= typ_d;
            err_conflict_q <= err_conflict_d;
            err_range_q    <= err_range_d;
        end
    end

    // Array is not reset. Preload goes first so channel writes override it,
    // and channels are applied in ascending order so the highest index wins.
    always_ff @(posedge clock) begin
        if (ld_hit) mem_q[ld_idx] <= load_data;
        for (int c = 0; c < N_CH; c++) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_en[c][b]) mem_q[wr_idx[c][b]] <= wr_val[c][b];
            end
        end
    end

    always_comb begin
        M_Rdata_ram = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_done[c]) M_Rdata_ram[c*DATA_W +: DATA_W] = rdata_q[c];
        end
    end

    assign M_DataRdy    = rd_done | wr_done;
    assign err_conflict = err_conflict_q;
    assign err_range    = err_range_q;

endmodule

// File: tb/tb_bambu_offchip_mem_model.sv
// -----------------------------------------------------------------------------
// tb_bambu_offchip_mem_model
//   Directed and random accesses against a byte-array reference model.
//   Drivers push expected completions (channel, cycle, data) into exp_q; the
//   monitor pops and compares on every M_DataRdy pulse and checks that read
//   data is zero in all other cycles.
// -----------------------------------------------------------------------------
module tb_bambu_offchip_mem_model;
    localparam int N_CH        = 2;
    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 16;
    localparam int BASE_ADDR   = 4;
    localparam int MEM_BYTES   = 32;
    localparam int READ_DELAY  = 3;
    localparam int WRITE_DELAY = 2;
    localparam int SIZE_W      = 7;

    logic                   clock;
    logic                   reset;
    logic [N_CH-1:0]        Mout_oe_ram;
    logic [N_CH-1:0]        Mout_we_ram;
    logic [N_CH*ADDR_W-1:0] Mout_addr_ram;
    logic [N_CH*DATA_W-1:0] Mout_Wdata_ram;
    logic [N_CH*SIZE_W-1:0] Mout_data_ram_size;
    logic [N_CH*DATA_W-1:0] M_Rdata_ram;
    logic [N_CH-1:0]        M_DataRdy;
    logic                   load_en;
    logic [ADDR_W-1:0]      load_addr;
    logic [7:0]             load_data;
    logic [N_CH-1:0]        err_conflict;
    logic [N_CH-1:0]        err_range;

    bambu_offchip_mem_model #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR),
        .MEM_BYTES(MEM_BYTES), .READ_DELAY(READ_DELAY), .WRITE_DELAY(WRITE_DELAY),
        .SIZE_W(SIZE_W)
    ) dut (
        .clock(clock), .reset(reset),
        .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram),
        .Mout_addr_ram(Mout_addr_ram), .Mout_Wdata_ram(Mout_Wdata_ram),
        .Mout_data_ram_size(Mout_data_ram_size),
        .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .err_conflict(err_conflict), .err_range(err_range)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]      ref_mem [MEM_BYTES];
    logic [N_CH-1:0] ref_err_range    = '0;
    logic [N_CH-1:0] ref_err_conflict = '0;

    function automatic bit in_win(input int a);
        return (a >= BASE_ADDR) && (a < BASE_ADDR + MEM_BYTES);
    endfunction

    function automatic int eff(input int s);
        return (s == 0 || s > DATA_W) ? DATA_W : s;
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input int a, input int s);
        logic [DATA_W-1:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < eff(s); i++) begin
            idx = a - BASE_ADDR + i / 8;
            if (idx < MEM_BYTES) r[i] = ref_mem[idx][i % 8];
        end
        return r;
    endfunction

    task automatic ref_write(input int a, input int s, input logic [DATA_W-1:0] d);
        int idx;
        for (int i = 0; i < eff(s); i++) begin
            idx = a - BASE_ADDR + i / 8;
            if (idx < MEM_BYTES) ref_mem[idx][i % 8] = d[i];
        end
    endtask

    function automatic bit runs_past(input int a, input int s);
        return in_win(a) && (a - BASE_ADDR + (eff(s) + 7) / 8 > MEM_BYTES);
    endfunction

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        int                ch;
        int                cyc;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t exp_q[$];
    int   mon_idx;

    always @(negedge clock) begin
        for (int c = 0; c < N_CH; c++) begin
            if (M_DataRdy[c]) begin
                mon_idx = -1;
                for (int k = 0; k < exp_q.size(); k++)
                    if (mon_idx < 0 && exp_q[k].ch == c) mon_idx = k;
                if (mon_idx < 0) begin
                    check($sformatf("unexpected_rdy_ch%0d", c), 1, 0);
                end else begin
                    check($sformatf("rdy_cycle_ch%0d", c), 64'(cyc), 64'(exp_q[mon_idx].cyc));
                    check($sformatf("rdata_ch%0d", c), 64'(M_Rdata_ram[c*DATA_W +: DATA_W]),
                          64'(exp_q[mon_idx].data));
                    exp_q.delete(mon_idx);
                end
            end else begin
                check($sformatf("rdata_idle_ch%0d", c), 64'(M_Rdata_ram[c*DATA_W +: DATA_W]), 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drop(input int c);
        Mout_oe_ram[c] = 1'b0;
        Mout_we_ram[c] = 1'b0;
    endtask

    task automatic preload(input int a, input logic [7:0] v);
        @(posedge clock); #1;
        load_en = 1'b1; load_addr = ADDR_W'(a); load_data = v;
        if (in_win(a)) ref_mem[a - BASE_ADDR] = v;
        @(posedge clock); #1;
        load_en = 1'b0;
    endtask

    // Starts up to two accesses in the same cycle. Reads see pre-state, then
    // writes apply in ascending channel order (both take effect at one edge).
    task automatic issue(input logic [N_CH-1:0] en, input logic [N_CH-1:0] wr,
                         input int a0, input int a1,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         input int s0, input int s1);
        int a[N_CH]; int s[N_CH]; logic [DATA_W-1:0] d[N_CH];
        logic [N_CH-1:0] pend, hold;
        int t, waited;
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1; s[0] = s0; s[1] = s1;
        @(posedge clock); #1;
        t = cyc;
        pend = '0;
        for (int c = 0; c < N_CH; c++) begin
            Mout_oe_ram[c] = en[c] & ~wr[c];
            Mout_we_ram[c] = en[c] & wr[c];
            Mout_addr_ram[c*ADDR_W +: ADDR_W]      = ADDR_W'(a[c]);
            Mout_Wdata_ram[c*DATA_W +: DATA_W]     = d[c];
            Mout_data_ram_size[c*SIZE_W +: SIZE_W] = SIZE_W'(s[c]);
            if (en[c] && in_win(a[c])) pend[c] = 1'b1;
            if (en[c] && runs_past(a[c], s[c])) ref_err_range[c] = 1'b1;
            if (en[c] && !wr[c] && in_win(a[c]))
                exp_q.push_back('{c, t + READ_DELAY - 1, ref_read(a[c], s[c])});
        end
        for (int c = 0; c < N_CH; c++) begin
            if (en[c] && wr[c] && in_win(a[c])) begin
                exp_q.push_back('{c, t + WRITE_DELAY - 1, '0});
                ref_write(a[c], s[c], d[c]);
            end
        end
        hold = en;
        waited = 0;
        while (hold != '0) begin
            @(negedge clock);
            for (int c = 0; c < N_CH; c++) begin
                if (pend[c] && M_DataRdy[c]) begin
                    pend[c] = 1'b0; hold[c] = 1'b0;
                end
                if (!pend[c] && hold[c] && waited >= 9) hold[c] = 1'b0;
            end
            if (waited >= 16) begin
                check("access_timeout", 64'(pend), 0);
                hold = '0;
            end
            @(posedge clock); #1;
            for (int c = 0; c < N_CH; c++) if (!hold[c]) drop(c);
            waited++;
        end
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_err_range"}, 64'(err_range), 64'(ref_err_range));
        check({tag, "_err_conflict"}, 64'(err_conflict), 64'(ref_err_conflict));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int t0;
    logic [N_CH-1:0] r_en, r_wr;

    initial begin
        reset = 1'b0;
        Mout_oe_ram = '0; Mout_we_ram = '0; Mout_addr_ram = '0;
        Mout_Wdata_ram = '0; Mout_data_ram_size = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        #2;
        check("reset_datardy", 64'(M_DataRdy), 0);
        check("reset_rdata", 64'(M_Rdata_ram), 0);
        check("reset_err_conflict", 64'(err_conflict), 0);
        check("reset_err_range", 64'(err_range), 0);
        #10 reset = 1'b1;

        for (int i = 0; i < MEM_BYTES; i++) preload(BASE_ADDR + i, 8'($urandom));
        preload(BASE_ADDR + 0, 8'h11);
        preload(BASE_ADDR + 1, 8'h22);
        preload(BASE_ADDR + 5, 8'h00);
        preload(BASE_ADDR + MEM_BYTES, 8'h5A);  // outside window: ignored
        preload(BASE_ADDR - 1, 8'hA5);          // below window: ignored

        // Basic read, byte-sized write then full-width read.
        issue(2'b01, 2'b00, BASE_ADDR + 1, 0, '0, '0, 8, 0);
        issue(2'b10, 2'b10, 0, BASE_ADDR + 4, '0, 16'hABCD, 0, 8);
        issue(2'b01, 2'b00, BASE_ADDR + 4, 0, '0, '0, 16, 0);
        issue(2'b01, 2'b00, BASE_ADDR + 0, 0, '0, '0, 0, 0);

        // Same-byte collision: channel 1 wins.
        issue(2'b11, 2'b11, BASE_ADDR + 3, BASE_ADDR + 3, 16'h0055, 16'h00AA, 8, 8);
        issue(2'b10, 2'b00, 0, BASE_ADDR + 3, '0, '0, 0, 8);

        // Cross-channel read and write of the same bytes at the same edge.
        issue(2'b11, 2'b10, BASE_ADDR + 6, BASE_ADDR + 6, '0, 16'h4321, 16, 16);
        issue(2'b01, 2'b00, BASE_ADDR + 6, 0, '0, '0, 16, 0);

        // Partial-byte write (12 bits) keeps upper nibble of second byte.
        issue(2'b01, 2'b01, BASE_ADDR + 10, 0, 16'hFFFF, '0, 12, 0);
        issue(2'b10, 2'b00, 0, BASE_ADDR + 10, '0, '0, 0, 16);

        // Out of window: no completion, no flags.
        issue(2'b01, 2'b00, 100, 0, '0, '0, 8, 0);
        check_errs("oow");

        // Running past the window end.
        issue(2'b10, 2'b00, 0, BASE_ADDR + MEM_BYTES - 1, '0, '0, 0, 16);
        issue(2'b01, 2'b01, BASE_ADDR + MEM_BYTES - 1, 0, 16'hBEEF, '0, 16, 0);
        issue(2'b01, 2'b00, BASE_ADDR + MEM_BYTES - 1, 0, '0, '0, 0, 0);
        check_errs("range");

        // Conflict: oe and we together on channel 0.
        @(posedge clock); #1;
        Mout_oe_ram[0] = 1'b1; Mout_we_ram[0] = 1'b1;
        Mout_addr_ram[0 +: ADDR_W] = ADDR_W'(BASE_ADDR + 2);
        Mout_Wdata_ram[0 +: DATA_W] = 16'hFFFF;
        Mout_data_ram_size[0 +: SIZE_W] = SIZE_W'(16);
        #1 check_errs("conflict_pre");
        ref_err_conflict[0] = 1'b1;
        @(posedge clock); #1;
        check_errs("conflict_set");
        repeat (4) @(posedge clock);
        #1 drop(0);
        repeat (3) @(posedge clock);
        #1 check_errs("conflict_sticky");
        issue(2'b01, 2'b00, BASE_ADDR + 2, 0, '0, '0, 16, 0);

        // Back-to-back reads: oe held across the first DataRdy.
        @(posedge clock); #1;
        t0 = cyc;
        Mout_oe_ram[1] = 1'b1;
        Mout_addr_ram[ADDR_W +: ADDR_W] = ADDR_W'(BASE_ADDR + 7);
        Mout_data_ram_size[SIZE_W +: SIZE_W] = SIZE_W'(16);
        exp_q.push_back('{1, t0 + READ_DELAY - 1, ref_read(BASE_ADDR + 7, 16)});
        exp_q.push_back('{1, t0 + 2 * READ_DELAY - 1, ref_read(BASE_ADDR + 7, 16)});
        repeat (2 * READ_DELAY) @(posedge clock);
        #1 drop(1);

        // Channel write overrides a preload of the same byte at the same edge.
        fork
            issue(2'b01, 2'b01, BASE_ADDR + 12, 0, 16'h1234, '0, 16, 0);
            begin
                @(posedge clock);
                @(posedge clock); #1;
                load_en = 1'b1; load_addr = ADDR_W'(BASE_ADDR + 12); load_data = 8'h99;
                @(posedge clock); #1;
                load_en = 1'b0;
            end
        join
        issue(2'b01, 2'b00, BASE_ADDR + 12, 0, '0, '0, 16, 0);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            r_en = N_CH'($urandom_range(3, 1));
            r_wr = N_CH'($urandom_range(3, 0));
            issue(r_en, r_wr,
                  $urandom_range(BASE_ADDR + MEM_BYTES + 6, 0),
                  $urandom_range(BASE_ADDR + MEM_BYTES + 6, 0),
                  DATA_W'($urandom), DATA_W'($urandom),
                  $urandom_range(20, 0), $urandom_range(20, 0));
        end
        check_errs("random");

        // Reset in the second cycle of a read: aborted, no DataRdy.
        @(posedge clock); #1;
        Mout_oe_ram[0] = 1'b1;
        Mout_addr_ram[0 +: ADDR_W] = ADDR_W'(BASE_ADDR + 2);
        Mout_data_ram_size[0 +: SIZE_W] = SIZE_W'(16);
        @(posedge clock); #3;
        reset = 1'b0;
        ref_err_range = '0; ref_err_conflict = '0;
        #1;
        check("midreset_datardy", 64'(M_DataRdy), 0);
        check("midreset_rdata", 64'(M_Rdata_ram), 0);
        check_errs("midreset");
        drop(0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        repeat (5) @(posedge clock);

        // Reset before a write commits: array unchanged.
        @(posedge clock); #1;
        Mout_we_ram[1] = 1'b1;
        Mout_addr_ram[ADDR_W +: ADDR_W] = ADDR_W'(BASE_ADDR + 8);
        Mout_Wdata_ram[DATA_W +: DATA_W] = 16'h7777;
        Mout_data_ram_size[SIZE_W +: SIZE_W] = SIZE_W'(16);
        #2 reset = 1'b0;
        drop(1);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;

        // Fresh accesses after reset.
        issue(2'b01, 2'b00, BASE_ADDR + 2, 0, '0, '0, 16, 0);
        issue(2'b10, 2'b00, 0, BASE_ADDR + 8, '0, '0, 0, 16);
        check_errs("final");

        repeat (3) @(posedge clock);
        check("exp_q_empty", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
